pipe_flush_ctrl: RTL
====================

// Module: pipe_flush_ctrl
// PURPOSE
//   Central pipeline sequencer for the 5-stage core. Drives the flush/stall inputs of
//   IF_ID, ID_EX, EX_MEM and MEM_WB, and owns the fetch redirect. Sources: MEM-stage
//   events (exception, ertn, idle, tlb/cacop refetch), EX branch redirect, LSU busy.
//   Implements the IDLE wait-for-interrupt state.
// PARAMETERS
//   ADDR_W      32  PC/address width
//   IDLE_CNT_W  32  width of idle_cycles perf counter
// PORTS
//   clk               in   1       clock
//   rst               in   1       reset, synchronous, active-high
//   mem_valid         in   1       MEM stage holds a valid instruction
//   mem_except        in   1       OR of MEM except_type
//   mem_is_ertn       in   1       MEM instruction is ertn
//   mem_is_idle       in   1       MEM instruction is idle
//   mem_refetch       in   1       MEM is tlb op or cacop (refetch at pc+4)
//   mem_pc            in   ADDR_W  MEM instruction pc
//   lsu_busy          in   1       dcache/LSU not done; MEM cannot retire
//   csr_eentry        in   ADDR_W  exception entry
//   csr_era           in   ADDR_W  ertn return address
//   int_pending       in   1       enabled interrupt pending
//   ex_valid          in   1       EX stage valid
//   ex_br_taken       in   1       EX branch mispredict/taken
//   ex_br_target      in   ADDR_W  branch target
//   if_redirect_ready in   1       fetch accepts redirect this cycle
//   flush_if_id/flush_id_ex/flush_ex_mem/flush_mem_wb  out 1 each  stage-reg flushes
//   stall_if/stall_id/stall_ex/stall_mem               out 1 each  stage-reg stalls
//   redirect_valid    out  1       fetch redirect request
//   redirect_pc       out  ADDR_W  redirect target
//   in_idle           out  1       state==IDLE
//   idle_cycles       out  IDLE_CNT_W  total cycles spent in IDLE (wraps)
// BEHAVIOUR
//   States: RUN, REDIRECT, IDLE. Reset -> RUN, saved_pc=0, idle_cycles=0; all outputs 0.
//   mem_evt = state!=IDLE & mem_valid & !lsu_busy & (mem_except|mem_is_ertn|mem_is_idle|mem_refetch).
//   MEM-event priority: except > ertn > idle > refetch.
//   Target: except->csr_eentry; ertn->csr_era; refetch->mem_pc+4 (mod 2^ADDR_W).
//   br_evt = state!=IDLE & ex_valid & ex_br_taken & !mem_evt (MEM is older, always wins).
//   Flushes (combinational, same cycle as event):
//     mem_evt: flush_if_id, flush_id_ex, flush_ex_mem = 1.
//     br_evt: flush_if_id, flush_id_ex = 1.
//   flush_mem_wb is never asserted; MEM instruction retires (exception/ertn/idle in WB).
//   Redirect:
//     redirect_valid = (mem_evt&!idle) | br_evt | state==REDIRECT.
//     redirect_pc = live target if event this cycle, else saved_pc.
//     Event and if_redirect_ready=1 -> stay RUN. Else latch target in saved_pc, go REDIRECT.
//     REDIRECT: hold redirect_valid; assert flush_if_id every cycle; ready=1 -> RUN next cycle.
//     New mem_evt in REDIRECT overrides saved_pc and target. br_evt in REDIRECT is ignored
//     (its wrong-path fetch is flushed).
//   Idle: mem_evt with idle selected -> IDLE next cycle; saved_pc = mem_pc+4; no redirect.
//     IDLE: stall_if=1; flush_if_id, flush_id_ex, flush_ex_mem=1; idle_cycles++ each cycle.
//     int_pending in IDLE -> REDIRECT next cycle with saved_pc. Interrupt then taken as a
//     MEM exception by the normal path.
//   lsu_busy=1 (RUN/REDIRECT): stall_if, stall_id, stall_ex, stall_mem=1; MEM events masked.
//   Stage regs give flush priority over stall.
//   rst in any state: next cycle RUN, all outputs 0, pending redirect dropped.
// TESTING
//   1. RUN; mem_valid=1, mem_except=1, csr_eentry=0x1C008000, ready=1 -> same cycle:
//      flush_if_id/id_ex/ex_mem=1, redirect 0x1C008000; next cycle all 0.
//   2. Same cycle: ex_br_taken target 0x1C000100 and mem_is_ertn with era 0x1C000200 ->
//      redirect_pc=0x1C000200, flush_ex_mem=1.
//   3. br_evt target 0x1C000100, ready=0 for 3 cycles then 1 -> redirect_valid held 4
//      cycles at 0x1C000100, flush_if_id each cycle, RUN on 5th.
//   4. idle at mem_pc 0x1C000010, int_pending after 5 IDLE cycles -> stall_if=1 for 5 cycles,
//      idle_cycles=5, then redirect 0x1C000014.
//   5. lsu_busy=1 with mem_except=1 for 4 cycles -> all 4 stalls=1, no flush/redirect;
//      busy drops -> exception taken that cycle.
//   6. rst while REDIRECT (ready=0) -> next cycle redirect_valid=0, state RUN, idle_cycles=0.

Source files
------------

// File: rtl/pipe_flush_ctrl.sv
// Central pipeline sequencer: turns MEM-stage events, EX branch redirects and LSU
// back-pressure into stage flush/stall controls, owns the fetch redirect and the IDLE wait state.
module pipe_flush_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int IDLE_CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic                  mem_except,
   input  logic                  mem_is_ertn,
   input  logic                  mem_is_idle,
   input  logic                  mem_refetch,
   input  logic [ADDR_W-1:0]     mem_pc,
   input  logic                  lsu_busy,
   input  logic [ADDR_W-1:0]     csr_eentry,
   input  logic [ADDR_W-1:0]     csr_era,
   input  logic                  int_pending,
   input  logic                  ex_valid,
   input  logic                  ex_br_taken,
   input  logic [ADDR_W-1:0]     ex_br_target,
   input  logic                  if_redirect_ready,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  flush_ex_mem,
   output logic                  flush_mem_wb,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  stall_ex,
   output logic                  stall_mem,
   output logic                  redirect_valid,
   output logic [ADDR_W-1:0]     redirect_pc,
   output logic                  in_idle,
   output logic [IDLE_CNT_W-1:0] idle_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      REDIRECT = 2'd1,
      IDLE     = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] saved_pc;
   logic [ADDR_W-1:0] saved_pc_nxt;

   logic              mem_any;
   logic              mem_evt;
   logic              sel_except;
   logic              sel_ertn;
   logic              sel_idle;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] mem_tgt;
   logic              mem_redir;
   logic              br_evt;
   logic              br_act;
   logic              evt_redir;
   logic [ADDR_W-1:0] evt_tgt;

   // Event decode: MEM is older than EX, so any MEM event suppresses the branch.
   // A branch seen while already redirecting is wrong-path and is dropped.
   always_comb begin
      mem_any    = mem_except | mem_is_ertn | mem_is_idle | mem_refetch;
      mem_evt    = (state != IDLE) & mem_valid & ~lsu_busy & mem_any;
      sel_except = mem_except;
      sel_ertn   = ~mem_except & mem_is_ertn;
      sel_idle   = ~mem_except & ~mem_is_ertn & mem_is_idle;
      pc_plus4   = mem_pc + ADDR_W'(4);
      if (sel_except)
         mem_tgt = csr_eentry;
      else if (sel_ertn)
         mem_tgt = csr_era;
      else
         mem_tgt = pc_plus4;
      mem_redir  = mem_evt & ~sel_idle;
      br_evt     = (state != IDLE) & ex_valid & ex_br_taken & ~mem_evt;
      br_act     = br_evt & (state == RUN);
      evt_redir  = mem_redir | br_act;
      evt_tgt    = mem_redir ? mem_tgt : ex_br_target;
   end

   // Next-state logic and saved redirect target.
   always_comb begin
      state_nxt    = state;
      saved_pc_nxt = saved_pc;
      unique case (state)
         RUN, REDIRECT: begin
            if (mem_evt && sel_idle) begin
               state_nxt    = IDLE;
               saved_pc_nxt = pc_plus4;
            end else if (evt_redir) begin
               saved_pc_nxt = evt_tgt;
               state_nxt    = if_redirect_ready ? RUN : REDIRECT;
            end else if (state == REDIRECT && if_redirect_ready) begin
               state_nxt = RUN;
            end
         end
         IDLE: begin
            if (int_pending)
               state_nxt = REDIRECT;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Stage controls; everything is held low while reset is asserted.
   always_comb begin
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      flush_mem_wb   = 1'b0;
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      stall_ex       = 1'b0;
      stall_mem      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      in_idle        = 1'b0;
      if (!rst) begin
         if (state == IDLE) begin
            in_idle      = 1'b1;
            stall_if     = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
         end else begin
            if (lsu_busy) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               stall_ex  = 1'b1;
               stall_mem = 1'b1;
            end
            if (mem_evt) begin
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
            end
            if (br_act) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
            if (state == REDIRECT)
               flush_if_id = 1'b1;
            redirect_valid = evt_redir | (state == REDIRECT);
            redirect_pc    = evt_redir ? evt_tgt : saved_pc;
         end
      end
   end

   // State register with synchronous reset; a pending redirect is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         saved_pc <= '0;
      end else begin
         state    <= state_nxt;
         saved_pc <= saved_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         idle_cycles <= '0;
      else if (state == IDLE)
         idle_cycles <= idle_cycles + IDLE_CNT_W'(1);
   end

endmodule
